bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD up/down timer with an internal borrow/carry chain, so there are no external borrow ports.
- Successor to the single-digit game timer cell. It adds:
  - a configurable number of digits and radix;
  - a loadable preset;
  - up/down mode;
  - a pause control;
  - optional auto-reload at the terminal count.
- Sits between the 1 Hz tick generator and the seven-segment display driver, and supplies the game-over timeout to the game controller.

Parameters:
- NUM_DIGITS, 2, number of cascaded digits; digit 0 is least significant.
- RADIX, 10, modulus of each digit, range 2..16. Digit values run 0..RADIX-1.
- AUTO_RELOAD, 0: when 1, a tick at the terminal count reloads the stored preset; when 0, the count saturates at the terminal count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  synchronous load of load_val into the digits and the preset register.
- load_val  in  4*NUM_DIGITS  preset value; digit i occupies bits [4i+3:4i].
- tick  in  1  single-cycle count-enable pulse.
- run  in  1  when 1, ticks are honoured; when 0, the timer is paused.
- dir  in  1  0 = count down, 1 = count up.
- digits  out  4*NUM_DIGITS  current count, registered.
- done  out  1  level; high while the count is at the terminal value for the current dir.
- timeout  out  1  registered one-cycle pulse on a counted arrival at the terminal value.

Behaviour:
- Reset (async, immediate):
  - digits = 0, preset register = 0, timeout = 0.
  - done therefore reads 1 if dir = 0, else 0.
- Terminal value:
  - down mode: all digits = 0.
  - up mode: all digits = RADIX-1.
  - done = terminal(digits, dir), computed combinationally from the registered digits.
- Per-edge priority: load > counted tick > hold.
- Load:
  - Each load_val digit ≥ RADIX is clamped to RADIX-1.
  - The clamped value is written to both digits and the preset register.
  - timeout = 0 in the load cycle, even if the loaded value is terminal.
  - A tick coincident with load is dropped.
- Counted tick: condition is tick & run & !load.
  - If !done, down mode: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0; a digit at 0 wraps to RADIX-1 when it borrows. All digits update on the same edge (single-cycle ripple, no per-digit latency).
  - If !done, up mode: the mirror of down mode. A digit increments when all lower digits are RADIX-1, and a digit at RADIX-1 wraps to 0.
  - If the next value is terminal, timeout = 1 on the same edge the digits reach the terminal value. It is cleared on the following edge unless re-asserted.
  - If done and AUTO_RELOAD = 1: digits <= preset register; no timeout pulse.
  - If done and AUTO_RELOAD = 0: digits hold; no pulse, no wrap.
- run = 0: ticks are ignored and the digits hold. load still works.
- dir change: takes effect immediately on done, and on the next counted tick for counting. No pulse is generated by the change itself.
- timeout is 0 whenever no counted tick to the terminal value occurred in the previous cycle.
- Reset asserted mid-count: all state clears asynchronously; counting resumes only after rst deasserts and a load or tick arrives.
- Width rule: digit arithmetic is 4-bit. Values ≥ RADIX never appear in digits after reset, given the clamping.

Decomposition:
- Shared package timer_pkg:
  - DIGIT_W = 4;
  - dir encoding constants DIR_DOWN = 0, DIR_UP = 1;
  - a function clamp_digit(value, radix).
- Sub-module bcd_digit_cell, one per digit:
  - inputs: en_borrow (down), en_carry (up), load, load_digit;
  - outputs: value, is_zero, is_max.
- The top level generates NUM_DIGITS instances. It forms the chain enables as the AND of the lower digits' is_zero/is_max flags, and holds the preset register, the timeout register and the done logic.

Test Plan (NUM_DIGITS = 2, RADIX = 10 unless stated):
- Reset, then load 0x30 with dir = 0, run = 1, then 30 ticks → digits step 30, 29 … 10, 09 … 01, 00; timeout is high exactly in the cycle digits = 00; done = 1 thereafter; a further tick leaves 00 with no pulse.
- Load 0x10, dir = 0, 1 tick → digits = 09 (borrow from digit 1 to digit 0, both digits update in one edge), timeout = 0.
- AUTO_RELOAD = 1, load 0x02, 3 ticks → 01, 00 (timeout pulses), then 02 with no pulse.
- dir = 1, load 0x97, 2 ticks → 98, 99 with timeout on 99; a third tick holds 99 and done = 1.
- Load and tick in the same cycle with load_val 0x5C → digits = 59 (0xC clamped to 9), tick dropped; run = 0 with 5 ticks → digits stay 59.
- Assert rst asynchronously mid-count at 0x42 → digits = 00 and timeout = 0 without waiting for a clk edge; no pulse after deassertion until a counted tick arrives.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and digit helpers for the BCD timer
package timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP = 1'b1;

    // Out-of-range preset digits saturate to the largest legal digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                       input int radix);
        if (int'(value) >= radix)
            return DIGIT_W'(radix - 1);
        return value;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one loadable up/down digit with wrap at 0 and RADIX-1
module bcd_digit_cell
    import timer_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               en_borrow,
    input  logic               en_carry,
    output logic [DIGIT_W-1:0] value,
    output logic               is_zero,
    output logic               is_max
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 1);

    assign is_zero = (value == '0);
    assign is_max  = (value == MAX_DIGIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_digit;
        else if (en_borrow)
            value <= is_zero ? MAX_DIGIT : value - DIGIT_W'(1);
        else if (en_carry)
            value <= is_max ? '0 : value + DIGIT_W'(1);
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit up/down timer with preset, pause and terminal pulse
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int RADIX       = 10,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    input  logic                          tick,
    input  logic                          run,
    input  logic                          dir,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          done,
    output logic                          timeout
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 1);
    localparam logic [DIGIT_W-1:0] PRE_MAX   = DIGIT_W'(RADIX - 2);

    logic [DIGIT_W*NUM_DIGITS-1:0] clamped;
    logic [DIGIT_W*NUM_DIGITS-1:0] preset;
    logic [DIGIT_W*NUM_DIGITS-1:0] cell_load_val;
    logic [NUM_DIGITS-1:0]         is_zero;
    logic [NUM_DIGITS-1:0]         is_max;
    logic [NUM_DIGITS-1:0]         en_borrow;
    logic [NUM_DIGITS-1:0]         en_carry;
    logic count, step, reload, cell_load;
    logic lower_zero, lower_max, hi_zero, hi_max, near_term;

    assign done      = (dir == DIR_UP) ? &is_max : &is_zero;
    assign count     = tick & run & ~load;
    assign step      = count & ~done;
    assign reload    = (AUTO_RELOAD != 0) & count & done;
    assign cell_load = load | reload;
    assign cell_load_val = load ? clamped : preset;

    always_comb begin
        clamped    = '0;
        en_borrow  = '0;
        en_carry   = '0;
        lower_zero = 1'b1;
        lower_max  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[DIGIT_W*i +: DIGIT_W] = clamp_digit(load_val[DIGIT_W*i +: DIGIT_W], RADIX);
            en_borrow[i] = step & (dir == DIR_DOWN) & lower_zero;
            en_carry[i]  = step & (dir == DIR_UP) & lower_max;
            lower_zero   = lower_zero & is_zero[i];
            lower_max    = lower_max & is_max[i];
        end
    end

    // One step from terminal: digit 0 is one away and every higher digit is already terminal.
    always_comb begin
        hi_zero = 1'b1;
        hi_max  = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            hi_zero = hi_zero & is_zero[i];
            hi_max  = hi_max & is_max[i];
        end
        if (dir == DIR_UP)
            near_term = (digits[DIGIT_W-1:0] == PRE_MAX) & hi_max;
        else
            near_term = (digits[DIGIT_W-1:0] == DIGIT_W'(1)) & hi_zero;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell #(.RADIX(RADIX)) u_cell (
            .clk        (clk),
            .rst        (rst),
            .load       (cell_load),
            .load_digit (cell_load_val[DIGIT_W*g +: DIGIT_W]),
            .en_borrow  (en_borrow[g]),
            .en_carry   (en_carry[g]),
            .value      (digits[DIGIT_W*g +: DIGIT_W]),
            .is_zero    (is_zero[g]),
            .is_max     (is_max[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preset  <= '0;
            timeout <= 1'b0;
        end else begin
            if (load)
                preset <= clamped;
            timeout <= step & near_term;
        end
    end

    logic unused_max;
    assign unused_max = ^MAX_DIGIT;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed and random checks of saturating and auto-reload timers
module tb_bcd_countdown_timer;

    localparam int ND   = 2;
    localparam int RX   = 10;
    localparam int MAXV = RX ** ND - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       tick = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] digits_s, digits_r;
    logic       done_s, done_r, timeout_s, timeout_r;

    int errors = 0;
    int checks = 0;
    int mval[2];
    int mpre[2];
    bit mto[2];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(ND), .RADIX(RX), .AUTO_RELOAD(0)) dut_sat (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick(tick),
        .run(run), .dir(dir), .digits(digits_s), .done(done_s), .timeout(timeout_s)
    );

    bcd_countdown_timer #(.NUM_DIGITS(ND), .RADIX(RX), .AUTO_RELOAD(1)) dut_ar (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .tick(tick),
        .run(run), .dir(dir), .digits(digits_r), .done(done_r), .timeout(timeout_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min9(input int v);
        return (v > RX - 1) ? RX - 1 : v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % RX);
        r[7:4] = 4'(v / RX);
        return r;
    endfunction

    task automatic check_all(input string tag);
        int term;
        term = dir ? MAXV : 0;
        chk({tag, ".sat.digits"}, digits_s, to_bcd(mval[0]));
        chk({tag, ".sat.done"}, done_s, mval[0] == term);
        chk({tag, ".sat.timeout"}, timeout_s, mto[0]);
        chk({tag, ".ar.digits"}, digits_r, to_bcd(mval[1]));
        chk({tag, ".ar.done"}, done_r, mval[1] == term);
        chk({tag, ".ar.timeout"}, timeout_r, mto[1]);
    endtask

    task automatic step(input string tag, input logic ld, input logic [7:0] lv,
                        input logic tk, input logic rn, input logic dr);
        int term;
        load = ld; load_val = lv; tick = tk; run = rn; dir = dr;
        @(posedge clk);
        term = dr ? MAXV : 0;
        for (int k = 0; k < 2; k++) begin
            mto[k] = 1'b0;
            if (ld) begin
                mval[k] = min9(int'(lv[3:0])) + RX * min9(int'(lv[7:4]));
                mpre[k] = mval[k];
            end else if (tk && rn) begin
                if (mval[k] == term) begin
                    if (k == 1) mval[k] = mpre[k];
                end else begin
                    mval[k] = dr ? mval[k] + 1 : mval[k] - 1;
                    if (mval[k] == term) mto[k] = 1'b1;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mval[k] = 0; mpre[k] = 0; mto[k] = 1'b0;
        end
        #12;
        chk("reset.digits", digits_s, 8'h00);
        chk("reset.timeout", timeout_s, 1'b0);
        chk("reset.done_down", done_s, 1'b1);
        dir = 1'b1;
        #1;
        chk("reset.done_up", done_s, 1'b0);
        dir = 1'b0;
        #1;
        rst = 1'b0;

        step("ld30", 1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step("down30", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("down30.end", digits_s, 8'h00);
        step("sat_hold", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        step("ld10", 1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        step("borrow", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("borrow.value", digits_s, 8'h09);

        step("ld02", 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("reload", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("reload.value", digits_r, 8'h02);

        step("ld97", 1'b1, 8'h97, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("up", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("up.hold", digits_s, 8'h99);

        step("ld5c_tick", 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0);
        chk("clamp.value", digits_s, 8'h59);
        for (int i = 0; i < 5; i++) step("paused", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        step("ld42", 1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
        step("pre_rst", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.digits", digits_s, 8'h00);
        chk("async_rst.timeout", timeout_s, 1'b0);
        for (int k = 0; k < 2; k++) begin
            mval[k] = 0; mpre[k] = 0; mto[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic ld, tk, rn, dr;
            logic [7:0] lv;
            ld = ($urandom_range(0, 9) == 0);
            lv = 8'($urandom);
            tk = ($urandom_range(0, 1) == 1);
            rn = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            step("random", ld, lv, tk, rn, dr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
